// File: rtl/bcd7seg_pkg.sv
// Shared constants and helpers for the BCD seven-segment counter: digit width,
// active-high segment patterns (A = bit 0) and an integer-to-packed-BCD converter.
package bcd7seg_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Codes 10..15 never occur in normal operation; they show as blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  // Converts up to four decimal digits; used only on elaboration constants.
  function automatic logic [15:0] int_to_bcd(input int unsigned value);
    int unsigned rest;
    rest       = value;
    int_to_bcd = '0;
    for (int d = 0; d < 4; d++) begin
      int_to_bcd[BCD_W*d +: BCD_W] = 4'(rest % 10);
      rest = rest / 10;
    end
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Switch debouncer: the output level follows the raw input only after the two
// have disagreed for DEBOUNCE_LIMIT consecutive clock cycles.
module debounce_filter #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);

  logic [CNT_W-1:0] stable_cnt;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking assignments here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level      <= 1'b0;
      stable_cnt <= '0;
    end else if (raw == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_W'(DEBOUNCE_LIMIT - 1)) begin
      level      <= raw;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_counter_7seg.sv
// Multi-digit BCD up/down counter with debounced switches, wrap pulse and
// registered seven-segment decode. Define AUTO_REPEAT_EN for hold-to-repeat.
module bcd_counter_7seg
  import bcd7seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int MAX_VALUE      = 99,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int HOLD_DELAY     = 12500000,
  parameter int REPEAT_PERIOD  = 2500000
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic                        i_Switch_Up,
  input  logic                        i_Switch_Down,
  input  logic                        i_Switch_Clear,
  output logic [BCD_W*NUM_DIGITS-1:0] o_Count_BCD,
  output logic                        o_Wrap,
  output logic [7*NUM_DIGITS-1:0]     o_Segment
);

  localparam int CW = BCD_W * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;

  localparam logic [15:0]   MAX_BCD_ALL = int_to_bcd(MAX_VALUE);
  localparam logic [CW-1:0] MAX_BCD     = MAX_BCD_ALL[CW-1:0];
  localparam logic [6:0]    SEG_ZERO    = (SEG_ACTIVE_LOW != 0) ? ~SEG_0 : SEG_0;
  localparam logic [SW-1:0] SEG_RESET   = {NUM_DIGITS{SEG_ZERO}};

  logic          level_up, level_down, level_clear;
  logic          prev_up, prev_down, prev_clear;
  logic          press_up, press_down, press_clear;
  logic          step_up, step_down;
  logic [CW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] seg_q, seg_d;

  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_up (
    .clk(i_Clk), .rst(i_Rst), .raw(i_Switch_Up), .level(level_up)
  );
  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_down (
    .clk(i_Clk), .rst(i_Rst), .raw(i_Switch_Down), .level(level_down)
  );
  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_clear (
    .clk(i_Clk), .rst(i_Rst), .raw(i_Switch_Clear), .level(level_clear)
  );

  assign press_up    = level_up & ~prev_up;
  assign press_down  = level_down & ~prev_down;
  assign press_clear = level_clear & ~prev_clear;

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  // Index 0 = Up, 1 = Down. hold_cnt counts down to the next repeat step.
  logic [1:0]        armed;
  logic [1:0]        rep_step;
  logic [1:0]        held;
  logic [1:0]        pressed;
  logic [HOLD_W-1:0] hold_cnt [2];

  assign held    = {level_down, level_up};
  assign pressed = {press_down, press_up};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rep_step[i] = armed[i] && held[i] && (hold_cnt[i] == '0);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      armed <= '0;
      for (int i = 0; i < 2; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (press_clear || !held[i]) begin
          armed[i]    <= 1'b0;
          hold_cnt[i] <= '0;
        end else if (pressed[i]) begin
          armed[i]    <= 1'b1;
          hold_cnt[i] <= HOLD_W'(HOLD_DELAY - 2);
        end else if (armed[i]) begin
          hold_cnt[i] <= (hold_cnt[i] == '0) ? HOLD_W'(REPEAT_PERIOD - 1)
                                             : hold_cnt[i] - 1'b1;
        end
      end
    end
  end

  assign step_up   = press_up | rep_step[0];
  assign step_down = press_down | rep_step[1];
`else
  assign step_up   = press_up;
  assign step_down = press_down;
`endif

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] value);
    logic       carry;
    logic [3:0] digit;
    bcd_inc = value;
    carry   = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      digit = value[BCD_W*d +: BCD_W];
      if (carry) begin
        if (digit == 4'd9) begin
          bcd_inc[BCD_W*d +: BCD_W] = 4'd0;
        end else begin
          bcd_inc[BCD_W*d +: BCD_W] = digit + 4'd1;
          carry = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] value);
    logic       borrow;
    logic [3:0] digit;
    bcd_dec = value;
    borrow  = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      digit = value[BCD_W*d +: BCD_W];
      if (borrow) begin
        if (digit == 4'd0) begin
          bcd_dec[BCD_W*d +: BCD_W] = 4'd9;
        end else begin
          bcd_dec[BCD_W*d +: BCD_W] = digit - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  endfunction

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (press_clear) begin
      count_d = '0;
    end else if (step_up && !step_down) begin
      if (count_q == MAX_BCD) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = bcd_inc(count_q);
      end
    end else if (step_down && !step_up) begin
      if (count_q == '0) begin
        count_d = MAX_BCD;
        wrap_d  = 1'b1;
      end else begin
        count_d = bcd_dec(count_q);
      end
    end
  end

  always_comb begin
    seg_d = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      seg_d[7*d +: 7] = (SEG_ACTIVE_LOW != 0) ? ~seg_decode(count_q[BCD_W*d +: BCD_W])
                                              :  seg_decode(count_q[BCD_W*d +: BCD_W]);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      prev_up    <= 1'b0;
      prev_down  <= 1'b0;
      prev_clear <= 1'b0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      seg_q      <= SEG_RESET;
    end else begin
      prev_up    <= level_up;
      prev_down  <= level_down;
      prev_clear <= level_clear;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      seg_q      <= seg_d;
    end
  end

  assign o_Count_BCD = count_q;
  assign o_Wrap      = wrap_q;
  assign o_Segment   = seg_q;

endmodule
